// File: rtl/unet_mbx_pkg.sv
// Shared definitions for the U-Net mailbox controller: sequencer states,
// status words written back to the PS, and the mailbox word addressing helper.
package unet_mbx_pkg;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_POLL,
        ST_POLL_WAIT,
        ST_RD_DESC,
        ST_START,
        ST_WAIT_DONE,
        ST_WR_STAT,
        ST_CLR_CMD
    } mbx_state_t;

    localparam logic [31:0] STATUS_OK  = 32'hC0DE_0001;
    localparam logic [31:0] STATUS_TMO = 32'hC0DE_00EE;

    // Descriptor index width; enough for up to 8 descriptors
    localparam int IDX_W = 3;

    // Byte address of mailbox word k relative to the mailbox base
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] k);
        return base + (k << 2);
    endfunction

endpackage

// File: rtl/mbx_rd_pipe.sv
// Tags in-flight BRAM reads: a LAT-deep shift register carrying a valid bit
// and the descriptor index, so each returning word lands in the right slot.
module mbx_rd_pipe
    import unet_mbx_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LAT-1:0]   vld;
    logic [IDX_W-1:0] idx [LAT];

    // Shift the read tag one stage per cycle so it emerges with its data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_idx   = idx[LAT-1];

endmodule

// File: rtl/unet_mailbox_ctrl.sv
// U-Net mailbox controller: polls the PS command word in BRAM, fetches the
// layer descriptors, launches the accelerator, reports status and re-arms.
module unet_mailbox_ctrl
    import unet_mbx_pkg::*;
#(
    parameter logic [31:0] START_ADDR  = 32'h4580_0000,
    parameter int          NDESC       = 4,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] GO_MAGIC    = 32'h0005_0010,
    parameter int          POLL_GAP    = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ram_clk,
    output logic                  ram_rst,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_addr,
    output logic [31:0]           ram_wd_data,
    input  logic [31:0]           ram_rd_data,
    output logic [32*NDESC-1:0]   cfg_addr,
    output logic                  cfg_valid,
    output logic                  acc_start,
    input  logic                  acc_done,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [15:0]           run_cnt
);

    mbx_state_t       state;
    mbx_state_t       state_nxt;
    logic [31:0]      cnt;
    logic             rd_issue;
    logic [IDX_W-1:0] rd_idx;
    logic             go_match;
    logic             tmo_hit;
    logic             pipe_valid;
    logic [IDX_W-1:0] pipe_idx;

    assign ram_clk = clk;
    assign ram_rst = 1'b0;

    mbx_rd_pipe #(.LAT(RD_LAT)) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_issue),
        .in_idx    (rd_idx),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    // State register plus a per-state cycle counter that restarts on every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_GAP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    // Next-state decode and BRAM / accelerator strobes for the current state
    always_comb begin
        state_nxt   = state;
        ram_en      = 1'b0;
        ram_we      = 4'h0;
        ram_addr    = '0;
        ram_wd_data = '0;
        acc_start   = 1'b0;
        cfg_valid   = 1'b0;
        busy        = 1'b1;
        rd_issue    = 1'b0;
        rd_idx      = '0;
        go_match    = 1'b0;
        tmo_hit     = 1'b0;
        case (state)
            ST_GAP: begin
                busy = 1'b0;
                if (cnt == 32'(POLL_GAP - 1)) begin
                    state_nxt = ST_POLL;
                end
            end
            ST_POLL: begin
                busy      = 1'b0;
                ram_en    = 1'b1;
                ram_addr  = START_ADDR;
                state_nxt = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                busy = 1'b0;
                if (cnt == 32'(RD_LAT - 1)) begin
                    if (ram_rd_data == GO_MAGIC) begin
                        go_match  = 1'b1;
                        state_nxt = ST_RD_DESC;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_RD_DESC: begin
                if (cnt < 32'(NDESC)) begin
                    ram_en   = 1'b1;
                    ram_addr = word_addr(START_ADDR, cnt + 32'd1);
                    rd_issue = 1'b1;
                    rd_idx   = cnt[IDX_W-1:0];
                end
                if (cnt == 32'(NDESC + RD_LAT - 1)) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                acc_start = 1'b1;
                cfg_valid = 1'b1;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                cfg_valid = 1'b1;
                if (acc_done) begin
                    state_nxt = ST_WR_STAT;
                end else if (cnt == TIMEOUT_CYC - 32'd1) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_WR_STAT;
                end
            end
            ST_WR_STAT: begin
                ram_en      = 1'b1;
                ram_we      = 4'hF;
                ram_addr    = word_addr(START_ADDR, 32'(NDESC + 1));
                ram_wd_data = err_timeout ? STATUS_TMO : STATUS_OK;
                state_nxt   = ST_CLR_CMD;
            end
            ST_CLR_CMD: begin
                ram_en      = 1'b1;
                ram_we      = 4'hF;
                ram_addr    = START_ADDR;
                ram_wd_data = '0;
                state_nxt   = ST_GAP;
            end
            default: begin
                state_nxt = ST_GAP;
            end
        endcase
    end

    // Descriptor capture, sticky timeout flag and completed-run counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_addr    <= '0;
            err_timeout <= 1'b0;
            run_cnt     <= '0;
        end else begin
            for (int i = 0; i < NDESC; i++) begin
                if (pipe_valid && pipe_idx == IDX_W'(i)) begin
                    cfg_addr[32*i +: 32] <= ram_rd_data;
                end
            end
            if (go_match) begin
                err_timeout <= 1'b0;
            end else if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
            if (state == ST_CLR_CMD) begin
                run_cnt <= run_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_unet_mailbox_ctrl.sv
// Directed bench for unet_mailbox_ctrl. Instance A (NDESC=4, RD_LAT=1,
// timeout 50) covers polling, normal runs, timeout and reset mid-run;
// instance B (NDESC=8, RD_LAT=3) covers deep read pipelining.
module tb_unet_mailbox_ctrl;

    localparam logic [31:0] SA   = 32'h4580_0000;
    localparam logic [31:0] GO   = 32'h0005_0010;
    localparam logic [31:0] S_OK = 32'hC0DE_0001;
    localparam logic [31:0] S_TM = 32'hC0DE_00EE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn_a, rstn_b;
    logic          a_ram_clk, a_ram_rst, a_en, a_cfg_valid, a_start, a_done, a_busy, a_err;
    logic [3:0]    a_we;
    logic [31:0]   a_addr, a_wd, a_rd;
    logic [127:0]  a_cfg;
    logic [15:0]   a_run;
    logic          b_ram_clk, b_ram_rst, b_en, b_cfg_valid, b_start, b_done, b_busy, b_err;
    logic [3:0]    b_we;
    logic [31:0]   b_addr, b_wd, b_rd;
    logic [255:0]  b_cfg;
    logic [15:0]   b_run;

    unet_mailbox_ctrl #(.START_ADDR(SA), .NDESC(4), .RD_LAT(1), .GO_MAGIC(GO),
                        .POLL_GAP(16), .TIMEOUT_CYC(32'd50)) dut_a (
        .clk(clk), .rst_n(rstn_a), .ram_clk(a_ram_clk), .ram_rst(a_ram_rst),
        .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_wd_data(a_wd),
        .ram_rd_data(a_rd), .cfg_addr(a_cfg), .cfg_valid(a_cfg_valid),
        .acc_start(a_start), .acc_done(a_done), .busy(a_busy),
        .err_timeout(a_err), .run_cnt(a_run));

    unet_mailbox_ctrl #(.START_ADDR(SA), .NDESC(8), .RD_LAT(3), .GO_MAGIC(GO),
                        .POLL_GAP(4), .TIMEOUT_CYC(32'd50)) dut_b (
        .clk(clk), .rst_n(rstn_b), .ram_clk(b_ram_clk), .ram_rst(b_ram_rst),
        .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_wd_data(b_wd),
        .ram_rd_data(b_rd), .cfg_addr(b_cfg), .cfg_valid(b_cfg_valid),
        .acc_start(b_start), .acc_done(b_done), .busy(b_busy),
        .err_timeout(b_err), .run_cnt(b_run));

    logic [31:0] mem_a [16] = '{default: 32'h0};
    logic [31:0] mem_b [16] = '{default: 32'h0};
    logic        ps_we  = 1'b0;
    logic        ps_sel = 1'b0;
    logic [3:0]  ps_idx = 4'h0;
    logic [31:0] ps_dat = 32'h0;
    logic [31:0] b_p1, b_p2;

    // BRAM models: A has one cycle of read latency, B three; PS writes come in through ps_*
    always @(posedge clk) begin
        if (a_en) begin
            a_rd <= mem_a[a_addr[5:2]];
            if (a_we == 4'hF) mem_a[a_addr[5:2]] = a_wd;
        end
        b_p1 <= mem_b[b_addr[5:2]];
        b_p2 <= b_p1;
        b_rd <= b_p2;
        if (b_en && b_we == 4'hF) mem_b[b_addr[5:2]] = b_wd;
        if (ps_we && !ps_sel) mem_a[ps_idx] = ps_dat;
        if (ps_we && ps_sel) mem_b[ps_idx] = ps_dat;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int a_poll_cnt = 0, a_poll_last = 0, a_poll_prev = 0;
    int a_wr_cnt = 0, a_busy_seen = 0, a_start_cnt = 0, a_bad_addr = 0;
    int b_rd_run = 0, b_rd_run_max = 0, b_bad_addr = 0;

    // Bus activity monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (a_en && a_we == 4'h0 && a_addr == SA) begin
            a_poll_prev = a_poll_last;
            a_poll_last = cyc;
            a_poll_cnt++;
        end
        if (a_en && a_we != 4'h0) a_wr_cnt++;
        if (a_busy) a_busy_seen++;
        if (a_start) a_start_cnt++;
        if (a_en && a_addr[31:6] != SA[31:6]) a_bad_addr++;
        if (b_en && b_addr[31:6] != SA[31:6]) b_bad_addr++;
        if (b_en && b_we == 4'h0) begin
            b_rd_run++;
            if (b_rd_run > b_rd_run_max) b_rd_run_max = b_rd_run;
        end else begin
            b_rd_run = 0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel_b, input logic [3:0] idx, input logic [31:0] dat);
        @(negedge clk);
        ps_sel = sel_b;
        ps_idx = idx;
        ps_dat = dat;
        ps_we  = 1'b1;
        @(negedge clk);
        ps_we  = 1'b0;
    endtask

    task automatic wait_start(input bit sel_b, input int budget);
        int n = 0;
        while (!(sel_b ? b_start : a_start) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(sel_b ? "b_start_seen" : "a_start_seen", 256'(sel_b ? b_start : a_start), 256'h1);
    endtask

    task automatic wait_run(input bit sel_b, input logic [15:0] target, input int budget);
        int n = 0;
        while ((sel_b ? b_run : a_run) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(sel_b ? "b_run_cnt" : "a_run_cnt", 256'(sel_b ? b_run : a_run), 256'(target));
    endtask

    task automatic pulse_done(input bit sel_b);
        if (sel_b) b_done = 1'b1; else a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        b_done = 1'b0;
    endtask

    initial begin
        int snap_poll, snap_wr, snap_busy, snap_start;
        logic [255:0] exp_b;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        a_done = 1'b0;
        b_done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_ram_en", 256'(a_en), 256'h0);
        checkOutput("rst_ram_addr", 256'(a_addr), 256'h0);
        checkOutput("rst_ram_we", 256'(a_we), 256'h0);
        checkOutput("rst_busy", 256'(a_busy), 256'h0);
        checkOutput("rst_cfg", 256'(a_cfg), 256'h0);
        checkOutput("rst_misc", 256'({a_cfg_valid, a_start, a_err, a_run}), 256'h0);
        checkOutput("ram_rst", 256'({a_ram_rst, b_ram_rst}), 256'h0);
        checkOutput("ram_clk_low", 256'({a_ram_clk, b_ram_clk}), 256'h0);
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // Test 1: idle command word, polls only
        snap_poll = a_poll_cnt;
        snap_busy = a_busy_seen;
        repeat (100) @(negedge clk);
        checkOutput("poll_count_ge5", 256'(a_poll_cnt - snap_poll >= 5), 256'h1);
        checkOutput("poll_interval", 256'(a_poll_last - a_poll_prev), 256'd18);
        checkOutput("idle_no_writes", 256'(a_wr_cnt), 256'h0);
        checkOutput("idle_busy", 256'(a_busy_seen - snap_busy), 256'h0);
        checkOutput("idle_no_start", 256'(a_start_cnt), 256'h0);

        // Test 2: normal run, done 10 cycles after start
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 4'(k), 32'(k));
        applyStimulus(1'b0, 4'h0, GO);
        wait_start(1'b0, 200);
        checkOutput("t2_cfg_valid", 256'(a_cfg_valid), 256'h1);
        checkOutput("t2_busy", 256'(a_busy), 256'h1);
        repeat (10) @(negedge clk);
        pulse_done(1'b0);
        wait_run(1'b0, 16'd1, 20);
        checkOutput("t2_cfg_addr", 256'(a_cfg), 256'({32'd4, 32'd3, 32'd2, 32'd1}));
        checkOutput("t2_start_cnt", 256'(a_start_cnt), 256'd1);
        checkOutput("t2_status", 256'(mem_a[5]), 256'(S_OK));
        checkOutput("t2_cmd_cleared", 256'(mem_a[0]), 256'h0);
        checkOutput("t2_err", 256'(a_err), 256'h0);
        checkOutput("t2_cfg_valid_drop", 256'(a_cfg_valid), 256'h0);
        checkOutput("t2_cfg_hold", 256'(a_cfg[31:0]), 256'd1);

        // Test 3: timeout; a done pulse during START must be ignored
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 4'(k), 32'h10 * 32'(k));
        applyStimulus(1'b0, 4'h0, GO);
        wait_start(1'b0, 200);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        repeat (49) @(negedge clk);
        checkOutput("t3_err_before", 256'(a_err), 256'h0);
        checkOutput("t3_still_waiting", 256'(a_cfg_valid), 256'h1);
        @(negedge clk);
        checkOutput("t3_err_set", 256'(a_err), 256'h1);
        wait_run(1'b0, 16'd2, 20);
        checkOutput("t3_status", 256'(mem_a[5]), 256'(S_TM));
        checkOutput("t3_cmd_cleared", 256'(mem_a[0]), 256'h0);
        checkOutput("t3_cfg_addr", 256'(a_cfg), 256'({32'h40, 32'h30, 32'h20, 32'h10}));

        // Test 5: done coincides with last timeout cycle, OK wins
        applyStimulus(1'b0, 4'h0, GO);
        wait_start(1'b0, 200);
        checkOutput("t5_err_cleared_by_go", 256'(a_err), 256'h0);
        repeat (50) @(negedge clk);
        pulse_done(1'b0);
        wait_run(1'b0, 16'd3, 20);
        checkOutput("t5_status", 256'(mem_a[5]), 256'(S_OK));
        checkOutput("t5_err", 256'(a_err), 256'h0);

        // Test 5b: near-miss command word is ignored
        snap_start = a_start_cnt;
        snap_busy  = a_busy_seen;
        applyStimulus(1'b0, 4'h0, 32'h0005_0011);
        repeat (60) @(negedge clk);
        checkOutput("t5b_no_start", 256'(a_start_cnt - snap_start), 256'h0);
        checkOutput("t5b_no_busy", 256'(a_busy_seen - snap_busy), 256'h0);
        checkOutput("t5b_cmd_kept", 256'(mem_a[0]), 256'h0005_0011);
        checkOutput("t5b_run_cnt", 256'(a_run), 256'd3);

        // Test 6: reset during WAIT_DONE, then the still-armed GO runs normally
        applyStimulus(1'b0, 4'h5, 32'h0);
        applyStimulus(1'b0, 4'h0, GO);
        wait_start(1'b0, 200);
        repeat (5) @(negedge clk);
        snap_wr = a_wr_cnt;
        rstn_a = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_busy", 256'(a_busy), 256'h0);
        checkOutput("t6_rst_cfg", 256'(a_cfg), 256'h0);
        checkOutput("t6_rst_misc", 256'({a_en, a_cfg_valid, a_run}), 256'h0);
        repeat (3) @(negedge clk);
        checkOutput("t6_no_write", 256'(a_wr_cnt - snap_wr), 256'h0);
        checkOutput("t6_cmd_kept", 256'(mem_a[0]), 256'(GO));
        checkOutput("t6_no_status", 256'(mem_a[5]), 256'h0);
        rstn_a = 1'b1;
        wait_start(1'b0, 200);
        repeat (3) @(negedge clk);
        pulse_done(1'b0);
        wait_run(1'b0, 16'd1, 20);
        checkOutput("t6_status", 256'(mem_a[5]), 256'(S_OK));
        checkOutput("t6_cmd_cleared", 256'(mem_a[0]), 256'h0);
        checkOutput("t6_cfg_addr", 256'(a_cfg), 256'({32'h40, 32'h30, 32'h20, 32'h10}));
        checkOutput("a_addr_range", 256'(a_bad_addr), 256'h0);

        // Test 4: instance B, 8 descriptors with 3-cycle read latency
        exp_b = '0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 4'(k), 32'hB000_0000 + 32'(k));
            exp_b[32*(k-1) +: 32] = 32'hB000_0000 + 32'(k);
        end
        applyStimulus(1'b1, 4'h0, GO);
        wait_start(1'b1, 300);
        checkOutput("t4_cfg_addr", b_cfg, exp_b);
        checkOutput("t4_cfg_valid", 256'(b_cfg_valid), 256'h1);
        checkOutput("t4_busy", 256'(b_busy), 256'h1);
        checkOutput("t4_back_to_back", 256'(b_rd_run_max), 256'd8);
        repeat (2) @(negedge clk);
        pulse_done(1'b1);
        wait_run(1'b1, 16'd1, 20);
        checkOutput("t4_status", 256'(mem_b[9]), 256'(S_OK));
        checkOutput("t4_cmd_cleared", 256'(mem_b[0]), 256'h0);
        checkOutput("t4_err", 256'(b_err), 256'h0);
        checkOutput("b_addr_range", 256'(b_bad_addr), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
